// File: rtl/md_pkg.sv
// Shared MD force-path types: per-particle force writebacks, local force
// payloads and network packets.
package md_pkg;

   localparam int unsigned NUM_CELLS         = 64;
   localparam int unsigned CELL_COORD_WIDTH  = 3;
   localparam int unsigned PARTICLE_ID_WIDTH = 16;
   localparam int unsigned FORCE_WIDTH       = 48;
   localparam int unsigned NODE_ID_WIDTH     = 6;

   typedef struct packed {
      logic [CELL_COORD_WIDTH-1:0]  cell_z;
      logic [CELL_COORD_WIDTH-1:0]  cell_y;
      logic [CELL_COORD_WIDTH-1:0]  cell_x;
      logic [PARTICLE_ID_WIDTH-1:0] particle_id;
      logic [FORCE_WIDTH-1:0]       force_val;
   } force_wb_t;

   typedef struct packed {
      logic [PARTICLE_ID_WIDTH-1:0] particle_id;
      logic [FORCE_WIDTH-1:0]       force_val;
   } force_data_t;

   typedef struct packed {
      logic [NODE_ID_WIDTH-1:0] dest_id;
      force_data_t              payload;
   } packet_t;

endpackage

// File: rtl/force_wb_packetizer.sv
// Buffers force writebacks, maps cell -> node and routes each head entry to the
// network or the local accumulator. Optional macro ZERO_FORCE_FILTER_EN drops zero forces.
module force_wb_packetizer
   import md_pkg::*;
#(
   parameter int unsigned              FIFO_DEPTH    = 8,
   parameter int unsigned              CELLS_PER_DIM = 4,
   parameter logic [NODE_ID_WIDTH-1:0] MY_NODE_ID    = '0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wb_valid,
   output logic                                wb_ready,
   input  logic [$bits(force_wb_t)-1:0]        wb_data,
   output logic                                net_valid,
   input  logic                                net_ready,
   output logic [$bits(packet_t)-1:0]          net_pkt,
   output logic                                loc_valid,
   input  logic                                loc_ready,
   output logic [$bits(force_data_t)-1:0]      loc_data,
   output logic [$clog2(FIFO_DEPTH):0]         occupancy,
   output logic                                err_oob
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned PKT_W  = $bits(packet_t);
   localparam int unsigned DATA_W = $bits(force_data_t);

   force_wb_t                wb;
   packet_t                  wb_pkt;
   packet_t                  head_n;
   packet_t                  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0]         cnt_q, cnt_n, cnt_after_pop;
   logic                     oob, drop, accept, push, pop;
   logic                     head_valid, head_local;

   assign wb        = force_wb_t'(wb_data);
   assign occupancy = cnt_q;

   // Cell -> node mapping, range check and FIFO bookkeeping for this cycle
   always_comb begin
      wb_pkt                     = '0;
      wb_pkt.dest_id             = NODE_ID_WIDTH'(32'(wb.cell_z) * CELLS_PER_DIM * CELLS_PER_DIM
                                                  + 32'(wb.cell_y) * CELLS_PER_DIM
                                                  + 32'(wb.cell_x));
      wb_pkt.payload.particle_id = wb.particle_id;
      wb_pkt.payload.force_val   = wb.force_val;

      oob = (32'(wb.cell_x) >= CELLS_PER_DIM) ||
            (32'(wb.cell_y) >= CELLS_PER_DIM) ||
            (32'(wb.cell_z) >= CELLS_PER_DIM);
`ifdef ZERO_FORCE_FILTER_EN
      drop = oob || (wb.force_val == '0);
`else
      drop = oob;
`endif
      accept = wb_valid && wb_ready;
      push   = accept && !drop;
      pop    = (net_valid && net_ready) || (loc_valid && loc_ready);

      cnt_after_pop = cnt_q - CNT_W'(pop);
      cnt_n         = cnt_after_pop + CNT_W'(push);
      rd_ptr_n      = rd_ptr_q + PTR_W'(pop);
      wr_ptr_n      = wr_ptr_q + PTR_W'(push);

      // When nothing older remains, the incoming entry becomes the head directly
      head_n     = (cnt_after_pop == '0) ? wb_pkt : mem[rd_ptr_n];
      head_valid = (cnt_n != '0);
      head_local = (head_n.dest_id == MY_NODE_ID);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wb_pkt;
   end

   // Pointers, count and registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         wb_ready  <= 1'b1;
         net_valid <= 1'b0;
         net_pkt   <= '0;
         loc_valid <= 1'b0;
         loc_data  <= '0;
         err_oob   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_n;
         rd_ptr_q  <= rd_ptr_n;
         cnt_q     <= cnt_n;
         wb_ready  <= (cnt_n != CNT_W'(FIFO_DEPTH));
         net_valid <= head_valid && !head_local;
         net_pkt   <= (head_valid && !head_local) ? PKT_W'(head_n) : '0;
         loc_valid <= head_valid && head_local;
         loc_data  <= (head_valid && head_local) ? DATA_W'(head_n.payload) : '0;
         err_oob   <= accept && oob;
      end
   end

endmodule

// File: tb/tb_force_wb_packetizer.sv
// Self-checking bench for force_wb_packetizer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_force_wb_packetizer;
   import md_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CPD   = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   force_wb_t   wb_in;
   logic        net_valid;
   logic        net_ready;
   packet_t     net_pkt;
   logic        loc_valid;
   logic        loc_ready;
   force_data_t loc_data;
   logic [3:0]  occupancy;
   logic        err_oob;

   int total = 0;
   int bad   = 0;

   force_wb_packetizer #(.FIFO_DEPTH(DEPTH), .CELLS_PER_DIM(CPD), .MY_NODE_ID('0)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_in),
      .net_valid(net_valid), .net_ready(net_ready), .net_pkt(net_pkt),
      .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_data(loc_data),
      .occupancy(occupancy), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic force_wb_t mk(input int x, input int y, input int z, input int pid,
                                    input logic [47:0] f);
      force_wb_t w;
      w.cell_x      = 3'(x);
      w.cell_y      = 3'(y);
      w.cell_z      = 3'(z);
      w.particle_id = 16'(pid);
      w.force_val   = f;
      return w;
   endfunction

   // Reference model: queue of expected packets, updated at each clock edge
   packet_t mq[$];
   logic    exp_err;
   bit      m_pop, m_acc, m_oob, m_keep;
   packet_t m_pkt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_err = 1'b0;
      end else begin
         m_pop = (mq.size() > 0) && ((mq[0].dest_id == 6'd0) ? loc_ready : net_ready);
         m_acc = wb_valid && (mq.size() < DEPTH);
         m_oob = (wb_in.cell_x >= CPD) || (wb_in.cell_y >= CPD) || (wb_in.cell_z >= CPD);
`ifdef ZERO_FORCE_FILTER_EN
         m_keep = !m_oob && (wb_in.force_val != 48'd0);
`else
         m_keep = !m_oob;
`endif
         m_pkt.dest_id             = 6'(int'(wb_in.cell_z) * 16 + int'(wb_in.cell_y) * 4 + int'(wb_in.cell_x));
         m_pkt.payload.particle_id = wb_in.particle_id;
         m_pkt.payload.force_val   = wb_in.force_val;
         if (m_pop) void'(mq.pop_front());
         exp_err = m_acc && m_oob;
         if (m_acc && m_keep) mq.push_back(m_pkt);
      end
   end

   // Cycle-by-cycle comparison against the model
   packet_t hd;
   bit      hv, hl;
   always @(negedge clk) begin
      hv = mq.size() > 0;
      hd = hv ? mq[0] : '0;
      hl = hv && (hd.dest_id == 6'd0);
      check("occupancy", 128'(occupancy), 128'(mq.size()));
      check("wb_ready", 128'(wb_ready), 128'(mq.size() < DEPTH));
      check("net_valid", 128'(net_valid), 128'(hv && !hl));
      check("loc_valid", 128'(loc_valid), 128'(hl));
      check("err_oob", 128'(err_oob), 128'(exp_err));
      if (hv && !hl) check("net_pkt", 128'(net_pkt), 128'(hd));
      if (hl) check("loc_data", 128'(loc_data), 128'(hd.payload));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push1(input force_wb_t w);
      wb_in    = w;
      wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      wb_valid  = 1'b0;
      wb_in     = '0;
      net_ready = 1'b0;
      loc_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_occ", 128'(occupancy), 128'd0);
      check("rst_wb_ready", 128'(wb_ready), 128'd1);
      check("rst_valids", 128'({net_valid, loc_valid, err_oob}), 128'd0);
      check("rst_net_pkt", 128'(net_pkt), 128'd0);
      check("rst_loc_data", 128'(loc_data), 128'd0);
      rst_n = 1'b1;
      tick();

      // Remote cell (1,2,3) -> node 57, one cycle after acceptance
      push1(mk(1, 2, 3, 5, 48'hDEAD_BEEF_1234));
      @(negedge clk);
      check("remote_valid", 128'(net_valid), 128'd1);
      check("remote_loc_valid", 128'(loc_valid), 128'd0);
      check("remote_dest", 128'(net_pkt.dest_id), 128'd57);
      check("remote_pid", 128'(net_pkt.payload.particle_id), 128'd5);
      check("remote_force", 128'(net_pkt.payload.force_val), 128'hDEAD_BEEF_1234);
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
      @(negedge clk);
      check("remote_drained", 128'(net_valid), 128'd0);

      // Local cell held under back-pressure
      push1(mk(0, 0, 0, 7, 48'h0000_1111_2222));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("local_valid_held", 128'({loc_valid, net_valid}), 128'b10);
         check("local_data_held", 128'(loc_data), 128'({16'd7, 48'h0000_1111_2222}));
      end
      loc_ready = 1'b1;
      tick();
      loc_ready = 1'b0;

      // Fill beyond depth with the network stalled, then drain in order
      for (int i = 0; i < 9; i++) begin
         wb_in    = mk(1, i % 4, i / 4, 100 + i, 48'(i + 1));
         wb_valid = 1'b1;
         tick();
      end
      wb_valid = 1'b0;
      @(negedge clk);
      check("full_occ", 128'(occupancy), 128'd8);
      check("full_wb_ready", 128'(wb_ready), 128'd0);
      for (int k = 0; k < 8; k++) begin
         check("drain_order", 128'({net_valid, net_pkt.payload.particle_id}), 128'({1'b1, 16'(100 + k)}));
         net_ready = 1'b1;
         @(negedge clk);
      end
      check("drain_occ", 128'(occupancy), 128'd0);
      net_ready = 1'b0;
      tick();

      // Out-of-range cell dropped with a single-cycle error pulse
      push1(mk(4, 0, 0, 9, 48'h1));
      @(negedge clk);
      check("oob_pulse", 128'(err_oob), 128'd1);
      check("oob_occ", 128'(occupancy), 128'd0);
      @(negedge clk);
      check("oob_pulse_end", 128'(err_oob), 128'd0);
      tick();

      // Zero-force entry followed by a nonzero one
      push1(mk(2, 0, 0, 11, 48'h0));
      push1(mk(3, 0, 0, 12, 48'h42));
      @(negedge clk);
`ifdef ZERO_FORCE_FILTER_EN
      check("zf_occ", 128'(occupancy), 128'd1);
      check("zf_head", 128'(net_pkt.payload.particle_id), 128'd12);
`else
      check("zf_occ", 128'(occupancy), 128'd2);
      check("zf_head", 128'(net_pkt.payload.particle_id), 128'd11);
`endif
      net_ready = 1'b1;
      repeat (3) tick();
      net_ready = 1'b0;

      // Interleaved local/remote traffic with mixed back-pressure
      for (int i = 0; i < 24; i++) begin
         wb_valid  = (i % 4 != 3);
         wb_in     = mk(i % 2, 0, 0, 200 + i, 48'(i + 1) * 48'h1_0001);
         net_ready = (i % 3 != 0);
         loc_ready = (i % 5 != 1);
         tick();
      end
      wb_valid  = 1'b0;
      net_ready = 1'b1;
      loc_ready = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      check("mixed_drained", 128'(occupancy), 128'd0);

      // Asynchronous reset with entries queued
      net_ready = 1'b0;
      loc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wb_in    = mk(1, 1, 1, 300 + i, 48'h77);
         wb_valid = 1'b1;
         tick();
      end
      wb_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_occ", 128'(occupancy), 128'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_occ", 128'(occupancy), 128'd0);
      check("async_rst_valids", 128'({net_valid, loc_valid}), 128'd0);
      check("async_rst_wb_ready", 128'(wb_ready), 128'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("post_rst_occ", 128'(occupancy), 128'd0);
      check("post_rst_wb_ready", 128'(wb_ready), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
